// File: rtl/regfile_arbiter.sv
// Two-requester round-robin front end for a 16x8 tri-state register array.
// Serialises single reads/writes and whole-array clears onto the array pins.
module regfile_arbiter #(
  parameter int ADDR_W       = 4,
  parameter int DATA_W       = 8,
  parameter bit CLR_ON_START = 1'b1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              a_req,
  input  logic              a_we,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [DATA_W-1:0] a_wdata,
  output logic              a_ack,
  output logic              a_err,
  output logic [DATA_W-1:0] a_rdata,
  input  logic              b_req,
  input  logic              b_we,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic [DATA_W-1:0] b_wdata,
  output logic              b_ack,
  output logic              b_err,
  output logic [DATA_W-1:0] b_rdata,
  input  logic              clr_req,
  output logic              clr_done,
  output logic              busy,
  output logic              ra_enable,
  output logic              ra_reset,
  output logic              ra_read,
  output logic              ra_write,
  output logic [ADDR_W-1:0] ra_address,
  input  logic              ra_write_status,
  inout  wire  [DATA_W-1:0] ra_data
);

  typedef enum logic [2:0] {
    INIT, IDLE, CLR, RD_ISSUE, RD_CAPTURE, WR_ISSUE, WR_CHECK
  } state_t;

  state_t              state_q, state_d, cur;
  logic                start_q;
  logic                en_q, boot_clr_q, rr_last_q, owner_q, we_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   wdata_q, a_rdata_q, b_rdata_q;
  logic                a_ack_q, b_ack_q, a_err_q, b_err_q, clr_done_q;
  logic                a_cand, b_cand, pick_a, pick_b, grant, fin, fin_err;

  // The first cycle after reset release behaves as INIT; the register itself
  // holds IDLE so busy stays low while reset is asserted.
  assign cur = start_q ? INIT : state_q;

  // A requester still showing its ack this cycle is masked from arbitration.
  assign a_cand = a_req & ~a_ack_q;
  assign b_cand = b_req & ~b_ack_q;
  assign pick_b = b_cand & (~a_cand | ~rr_last_q);
  assign pick_a = a_cand & ~pick_b;
  assign grant  = (cur == IDLE) & ~clr_req & (pick_a | pick_b);

  always_comb begin
    state_d = state_q;
    case (cur)
      INIT:       state_d = CLR_ON_START ? CLR : IDLE;
      IDLE: begin
        if (clr_req)     state_d = CLR;
        else if (grant)  state_d = (pick_b ? b_we : a_we) ? WR_ISSUE : RD_ISSUE;
      end
      CLR:        state_d = IDLE;
      RD_ISSUE:   state_d = RD_CAPTURE;
      RD_CAPTURE: state_d = IDLE;
      WR_ISSUE:   state_d = WR_CHECK;
      WR_CHECK:   state_d = IDLE;
      default:    state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      start_q <= 1'b1;
    end else begin
      state_q <= state_d;
      start_q <= 1'b0;
    end
  end

  assign fin     = (state_q == RD_CAPTURE) | (state_q == WR_CHECK);
  assign fin_err = (state_q == WR_CHECK) & ~ra_write_status;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      en_q       <= 1'b0;
      boot_clr_q <= 1'b0;
      rr_last_q  <= 1'b1;
      owner_q    <= 1'b0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      a_ack_q    <= 1'b0;
      b_ack_q    <= 1'b0;
      a_err_q    <= 1'b0;
      b_err_q    <= 1'b0;
      a_rdata_q  <= '0;
      b_rdata_q  <= '0;
      clr_done_q <= 1'b0;
    end else begin
      en_q       <= 1'b1;
      a_ack_q    <= 1'b0;
      b_ack_q    <= 1'b0;
      clr_done_q <= 1'b0;
      if (cur == INIT) boot_clr_q <= CLR_ON_START;
      if (state_q == CLR) begin
        clr_done_q <= ~boot_clr_q;
        boot_clr_q <= 1'b0;
      end
      if (grant) begin
        owner_q   <= pick_b;
        rr_last_q <= pick_b;
        we_q      <= pick_b ? b_we    : a_we;
        addr_q    <= pick_b ? b_addr  : a_addr;
        wdata_q   <= pick_b ? b_wdata : a_wdata;
      end
      if (fin) begin
        if (owner_q) begin
          b_ack_q <= 1'b1;
          b_err_q <= fin_err;
          if (!we_q) b_rdata_q <= ra_data;
        end else begin
          a_ack_q <= 1'b1;
          a_err_q <= fin_err;
          if (!we_q) a_rdata_q <= ra_data;
        end
      end
    end
  end

  assign ra_enable  = en_q;
  assign ra_reset   = (state_q == CLR);
  assign ra_read    = (state_q == RD_ISSUE) | (state_q == RD_CAPTURE);
  assign ra_write   = (state_q == WR_ISSUE);
  assign ra_address = (ra_read | ra_write) ? addr_q : '0;
  assign ra_data    = ra_write ? wdata_q : 'z;
  assign busy       = (state_q != IDLE);
  assign a_ack      = a_ack_q;
  assign b_ack      = b_ack_q;
  assign a_err      = a_err_q;
  assign b_err      = b_err_q;
  assign a_rdata    = a_rdata_q;
  assign b_rdata    = b_rdata_q;
  assign clr_done   = clr_done_q;

endmodule

// File: tb/tb_regfile_arbiter.sv
// Bench for regfile_arbiter: behavioural array on the tri-state bus plus a
// transaction-level reference memory predicting read data, errors and order.
module tb_regfile_arbiter;
  logic       clk = 1'b0;
  logic       reset;
  logic [1:0] req, we, ack, err;
  logic [3:0] addr [2];
  logic [7:0] wdata[2];
  logic [7:0] rdata[2];
  logic       clr_req, clr_done, busy;
  logic       ra_enable, ra_reset, ra_read, ra_write, ws;
  logic [3:0] ra_address;
  wire  [7:0] ra_data;

  logic [7:0] arr    [16];
  logic [7:0] ref_mem[16];
  logic       fail_wr = 1'b0;
  int         n_tests = 0, n_fail = 0;
  int         ord[$];

  always #5 clk = ~clk;

  regfile_arbiter dut (
    .clk(clk), .reset(reset),
    .a_req(req[0]), .a_we(we[0]), .a_addr(addr[0]), .a_wdata(wdata[0]),
    .a_ack(ack[0]), .a_err(err[0]), .a_rdata(rdata[0]),
    .b_req(req[1]), .b_we(we[1]), .b_addr(addr[1]), .b_wdata(wdata[1]),
    .b_ack(ack[1]), .b_err(err[1]), .b_rdata(rdata[1]),
    .clr_req(clr_req), .clr_done(clr_done), .busy(busy),
    .ra_enable(ra_enable), .ra_reset(ra_reset), .ra_read(ra_read),
    .ra_write(ra_write), .ra_address(ra_address),
    .ra_write_status(ws), .ra_data(ra_data)
  );

  // Register array model: garbage contents while the controller is in reset,
  // synchronous clear, write_status reflects an injected write failure.
  assign ra_data = (ra_enable && ra_read) ? arr[ra_address] : 8'bz;
  always @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < 16; i++) arr[i] <= 8'($urandom);
      ws <= 1'b0;
    end else if (ra_enable && ra_reset) begin
      for (int i = 0; i < 16; i++) arr[i] <= 8'h00;
    end else if (ra_enable && ra_write) begin
      if (!fail_wr) arr[ra_address] <= ra_data;
      ws <= !fail_wr;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic ref_clear();
    for (int i = 0; i < 16; i++) ref_mem[i] = 8'h00;
  endtask

  // One transaction from port p; cont keeps req high straight from the previous one.
  task automatic txn(input int p, input bit w, input logic [3:0] a, input logic [7:0] d,
                     input bit lat_chk, input bit cont);
    int cyc = 0;
    bit seen = 0;
    if (!cont) @(negedge clk);
    req[p] = 1'b1; we[p] = w; addr[p] = a; wdata[p] = d;
    while (!seen && cyc < 40) begin
      @(posedge clk);
      @(negedge clk);
      cyc++;
      if (lat_chk && w && cyc == 1) begin
        chk("wr_issue_ctl", {ra_write, ra_read, ra_address}, {1'b1, 1'b0, a});
        chk("wr_issue_bus", ra_data, d);
      end
      if (ack[p]) seen = 1;
    end
    req[p] = 1'b0;
    chk($sformatf("ack_seen_p%0d", p), seen, 1);
    if (lat_chk) chk("latency", cyc, 3);
    if (w) begin
      chk($sformatf("wr_err_p%0d", p), err[p], fail_wr);
      if (!fail_wr) ref_mem[a] = d;
    end else begin
      chk($sformatf("rd_err_p%0d", p), err[p], 0);
      chk($sformatf("rdata_p%0d@%0h", p, a), rdata[p], ref_mem[a]);
    end
    ord.push_back(p);
  endtask

  task automatic port_seq(input int p, input logic [3:0] fa, input logic [7:0] fd,
                          input logic [3:0] base);
    logic [3:0] ra = base + 4'($urandom_range(0, 3));
    txn(p, 1, fa, fd, 0, 0);
    txn(p, 1, ra, 8'($urandom), 0, 1);
    txn(p, 0, ra, 8'h00, 0, 1);
    txn(p, 0, fa, 8'h00, 0, 1);
  endtask

  task automatic post_release_chk();
    @(negedge clk);
    chk("rel_enable", ra_enable, 1);
    chk("rel_clr", ra_reset, 1);
    chk("rel_busy", busy, 1);
    @(negedge clk);
    chk("rel_clr_end", {ra_reset, busy, ra_enable}, 3'b001);
    chk("rel_no_clr_done", clr_done, 0);
    ref_clear();
  endtask

  initial begin
    reset = 1'b0; req = '0; we = '0; clr_req = 1'b0;
    for (int i = 0; i < 2; i++) begin addr[i] = '0; wdata[i] = '0; end
    ref_clear();
    repeat (3) @(negedge clk);
    chk("rst_ctl", {ra_enable, ra_reset, ra_read, ra_write, busy, clr_done}, 6'b0);
    chk("rst_ack", {ack, err}, 4'b0);
    chk("rst_rdata", {rdata[0], rdata[1], 4'(ra_address)}, 20'h0);
    reset = 1'b1;
    post_release_chk();

    txn(0, 0, 4'h3, 8'h00, 1, 0);
    txn(0, 1, 4'h7, 8'hA5, 1, 0);
    txn(0, 0, 4'h7, 8'h00, 1, 0);
    fail_wr = 1'b1;
    txn(0, 1, 4'h7, 8'h3C, 1, 0);
    fail_wr = 1'b0;
    txn(1, 0, 4'h7, 8'h00, 1, 0);

    for (int k = 0; k < 30; k++) begin
      int p = int'($urandom_range(0, 1));
      bit w = 1'($urandom);
      fail_wr = w && ($urandom_range(0, 4) == 0);
      txn(p, w, 4'($urandom), 8'($urandom), 1, 0);
      fail_wr = 1'b0;
    end

    ord.delete();
    fork
      port_seq(0, 4'h1, 8'h11, 4'h4);
      port_seq(1, 4'h2, 8'h22, 4'h8);
    join
    chk("contend_cnt", ord.size(), 8);
    for (int i = 1; i < ord.size(); i++) chk($sformatf("alternate_%0d", i), ord[i], 1 - ord[i-1]);
    chk("contend_a", ref_mem[1], 8'h11);
    chk("contend_b", ref_mem[2], 8'h22);

    txn(1, 0, 4'h2, 8'h00, 1, 0);
    ord.delete();
    fork
      begin
        int cyc = 0;
        @(negedge clk);
        clr_req = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("clr_first", {ra_reset, ra_read, ra_write}, 3'b100);
        while (!clr_done && cyc < 20) begin @(posedge clk); @(negedge clk); cyc++; end
        clr_req = 1'b0;
        chk("clr_done_seen", clr_done, 1);
        ref_clear();
        ord.push_back(2);
      end
      txn(0, 0, 4'h1, 8'h00, 0, 0);
      txn(1, 0, 4'h2, 8'h00, 0, 0);
    join
    chk("clr_order_cnt", ord.size(), 3);
    if (ord.size() == 3) begin
      chk("clr_order_0", ord[0], 2);
      chk("clr_order_1", ord[1], 0);
      chk("clr_order_2", ord[2], 1);
    end

    @(negedge clk);
    req[0] = 1'b1; we[0] = 1'b0; addr[0] = 4'h5;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    chk("mid_rd_capture", {ra_read, ra_address}, {1'b1, 4'h5});
    #2 reset = 1'b0;
    #1;
    chk("mid_rst_ctl", {ra_enable, ra_reset, ra_read, ra_write, busy, 4'(ra_address)}, 9'h0);
    chk("mid_rst_ack", {ack[0], err[0], rdata[0]}, 10'h0);
    req[0] = 1'b0;
    repeat (2) begin
      @(negedge clk);
      chk("mid_rst_no_ack", {ack, clr_done}, 3'b0);
    end
    reset = 1'b1;
    post_release_chk();
    txn(0, 0, 4'h5, 8'h00, 1, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
